// File: rtl/trajectory_draw_sequencer_pkg.sv
// ============================================================================
// trajectory_draw_sequencer_pkg : framebuffer geometry and draw FSM encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package trajectory_draw_sequencer_pkg;

    localparam int unsigned FB_WIDTH    = 640;
    localparam int unsigned FB_HEIGHT   = 480;
    localparam int unsigned FB_PIX_MAX  = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned PIX_ADDR_W  = 19;

    localparam int unsigned TRAJ_DEPTH  = 400;
    localparam int unsigned TRAJ_ADDR_W = 9;
    localparam logic [7:0]  TRAJ_COLOR  = 8'hE0;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_RD = 3'd2,
        ST_PRESENT = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } draw_state_e;

    // Linear pixel location as stored in the trajectory memory.
    function automatic logic [PIX_ADDR_W-1:0] pix_loc(input int unsigned x,
                                                      input int unsigned y);
        return PIX_ADDR_W'(y * FB_WIDTH + x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/trajectory_draw_sequencer_fill.sv
// ============================================================================
// traj_fill_tracker : mirrors the trajectory write pointer and fill level
// Revision: 1.0
// ============================================================================
`default_nettype none

module traj_fill_tracker
    import trajectory_draw_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH  = TRAJ_DEPTH,
    parameter int unsigned ADDR_W = TRAJ_ADDR_W,
    parameter int unsigned FILL_W = $clog2(TRAJ_DEPTH + 1)
) (
    input  logic              clock_i,
    input  logic              resetn_i,
    input  logic              wr_pulse_i,
    input  logic              clear_i,
    output logic [ADDR_W-1:0] start_idx_o,
    output logic [FILL_W-1:0] fill_o
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FULL     = FILL_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q;
    logic [FILL_W-1:0] fill_q;

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (clear_i) begin
            // clear beats a coincident write; that write is not counted
            wr_ptr_q <= '0;
            fill_q   <= '0;
        end else if (wr_pulse_i) begin
            wr_ptr_q <= (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
            if (fill_q != FULL) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    // Once the ring has wrapped, the oldest entry sits at the write pointer.
    assign start_idx_o = (fill_q == FULL) ? wr_ptr_q : '0;
    assign fill_o      = fill_q;

endmodule

`default_nettype wire

// File: rtl/trajectory_draw_sequencer.sv
// ============================================================================
// trajectory_draw_sequencer : replays the trajectory ring into the framebuffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module trajectory_draw_sequencer
    import trajectory_draw_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH   = TRAJ_DEPTH,
    parameter int unsigned ADDR_W  = TRAJ_ADDR_W,
    parameter int unsigned DATA_W  = PIX_ADDR_W,
    parameter int unsigned PIX_MAX = FB_PIX_MAX,
    parameter int unsigned RD_LAT  = 1,
    parameter logic [7:0]  COLOR   = TRAJ_COLOR
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              wr_pulse,
    input  logic              clear,
    input  logic              vblank,
    output logic [ADDR_W-1:0] rd_draw_add,
    input  logic [DATA_W-1:0] rd_draw_out,
    output logic              px_valid,
    output logic [DATA_W-1:0] px_addr,
    output logic [7:0]        px_color,
    input  logic              px_ready,
    output logic              busy,
    output logic              frame_done,
    output logic              aborted
);

    localparam int unsigned       FILL_W    = $clog2(DEPTH + 1);
    localparam int unsigned       LAT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W-1:0] PIX_LIMIT = DATA_W'(PIX_MAX);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'(RD_LAT - 1);

    logic [ADDR_W-1:0] start_idx;
    logic [FILL_W-1:0] fill;

    draw_state_e       state_q;
    logic              vblank_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic [FILL_W-1:0] visited_q;
    logic [FILL_W-1:0] visited_d;
    logic [FILL_W-1:0] count_q;
    logic [LAT_W-1:0]  lat_q;
    logic              abort_pend_q;
    logic [ADDR_W-1:0] rd_draw_add_q;
    logic              px_valid_q;
    logic [DATA_W-1:0] px_addr_q;
    logic              frame_done_q;
    logic              aborted_q;

    logic              vblank_rise;
    logic              stop_req;

    traj_fill_tracker #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .FILL_W (FILL_W)
    ) u_fill (
        .clock_i     (clock),
        .resetn_i    (resetn),
        .wr_pulse_i  (wr_pulse),
        .clear_i     (clear),
        .start_idx_o (start_idx),
        .fill_o      (fill)
    );

    // A pass only makes sense inside blanking, so a low vblank level at any
    // point of the pass (not just its falling edge) abandons it.
    always_comb begin
        vblank_rise = vblank && !vblank_q;
        stop_req    = !vblank || clear;
        idx_d       = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        visited_d   = visited_q + 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            vblank_q      <= 1'b0;
            idx_q         <= '0;
            visited_q     <= '0;
            count_q       <= '0;
            lat_q         <= '0;
            abort_pend_q  <= 1'b0;
            rd_draw_add_q <= '0;
            px_valid_q    <= 1'b0;
            px_addr_q     <= '0;
            frame_done_q  <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            vblank_q     <= vblank;
            frame_done_q <= 1'b0;
            aborted_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (vblank_rise) begin
                        if (fill == '0) begin
                            frame_done_q <= 1'b1;
                        end else begin
                            state_q       <= ST_ISSUE;
                            idx_q         <= start_idx;
                            rd_draw_add_q <= start_idx;
                            count_q       <= fill;
                            visited_q     <= '0;
                            abort_pend_q  <= 1'b0;
                        end
                    end
                end

                ST_ISSUE: begin
                    if (stop_req) begin
                        state_q   <= ST_IDLE;
                        aborted_q <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT_RD;
                        lat_q   <= '0;
                    end
                end

                ST_WAIT_RD: begin
                    if (stop_req) begin
                        state_q   <= ST_IDLE;
                        aborted_q <= 1'b1;
                    end else if (lat_q == LAT_LAST) begin
                        px_addr_q  <= rd_draw_out;
                        px_valid_q <= (rd_draw_out < PIX_LIMIT);
                        state_q    <= ST_PRESENT;
                    end else begin
                        lat_q <= lat_q + 1'b1;
                    end
                end

                ST_PRESENT: begin
                    if (px_valid_q && !px_ready) begin
                        // Request is committed; remember the abort until it drains.
                        if (stop_req) begin
                            abort_pend_q <= 1'b1;
                        end
                    end else begin
                        px_valid_q <= 1'b0;
                        if (stop_req || abort_pend_q) begin
                            state_q      <= ST_IDLE;
                            aborted_q    <= 1'b1;
                            abort_pend_q <= 1'b0;
                        end else begin
                            state_q <= ST_NEXT;
                        end
                    end
                end

                ST_NEXT: begin
                    idx_q     <= idx_d;
                    visited_q <= visited_d;
                    if (visited_d == count_q) begin
                        state_q <= ST_DONE;
                    end else begin
                        state_q       <= ST_ISSUE;
                        rd_draw_add_q <= idx_d;
                    end
                end

                ST_DONE: begin
                    frame_done_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end

                default: begin
                    state_q    <= ST_IDLE;
                    px_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_draw_add = rd_draw_add_q;
    assign px_valid    = px_valid_q;
    assign px_addr     = px_addr_q;
    assign px_color    = COLOR;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;
    assign aborted     = aborted_q;

endmodule

`default_nettype wire

// File: tb/tb_trajectory_draw_sequencer.sv
// ============================================================================
// tb_trajectory_draw_sequencer : scoreboard bench for the trajectory replayer
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_trajectory_draw_sequencer;
    import trajectory_draw_sequencer_pkg::*;

    localparam int unsigned DEPTH  = 400;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned DATA_W = 19;
    localparam int unsigned RD_LAT = 1;
    localparam int unsigned PIXLIM = 307200;

    logic              clock    = 1'b0;
    logic              resetn   = 1'b0;
    logic              wr_pulse = 1'b0;
    logic              clear    = 1'b0;
    logic              vblank   = 1'b0;
    logic              px_ready = 1'b0;
    logic [ADDR_W-1:0] rd_draw_add;
    logic [DATA_W-1:0] rd_draw_out;
    logic              px_valid;
    logic [DATA_W-1:0] px_addr;
    logic [7:0]        px_color;
    logic              busy;
    logic              frame_done;
    logic              aborted;

    trajectory_draw_sequencer #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PIX_MAX (PIXLIM),
        .RD_LAT  (RD_LAT),
        .COLOR   (8'hE0)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .wr_pulse    (wr_pulse),
        .clear       (clear),
        .vblank      (vblank),
        .rd_draw_add (rd_draw_add),
        .rd_draw_out (rd_draw_out),
        .px_valid    (px_valid),
        .px_addr     (px_addr),
        .px_color    (px_color),
        .px_ready    (px_ready),
        .busy        (busy),
        .frame_done  (frame_done),
        .aborted     (aborted)
    );

    always #5 clock = ~clock;

    // Trajectory memory with a one-cycle synchronous read port.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clock) rd_draw_out <= mem[rd_draw_add];

    int                npass = 0;
    int                ntotal = 0;
    int                bwp, bfill;
    int                xfer_cnt = 0, fd_cnt = 0, ab_cnt = 0, valid_cnt = 0;
    logic              hold_q = 1'b0;
    logic [DATA_W-1:0] hold_addr;
    logic [DATA_W-1:0] exp_q [$];

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = '0;
    end

    // Scoreboard monitor: a handshake seen here completes on the next edge.
    always @(negedge clock) begin
        if (!resetn) begin
            hold_q = 1'b0;
        end else begin
            if (frame_done) fd_cnt++;
            if (aborted)    ab_cnt++;
            if (px_valid)   valid_cnt++;
            if (px_valid && hold_q) begin
                ntotal++;
                if (px_addr !== hold_addr)
                    $display("FAIL hold_stable: px_addr %0d, required %0d", px_addr, hold_addr);
                else npass++;
            end
            if (px_valid && px_ready) begin
                xfer_cnt++;
                ntotal++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pixel_order: px_addr %0d, required no transfer", px_addr);
                end else begin
                    logic [DATA_W-1:0] e;
                    e = exp_q.pop_front();
                    if (px_addr !== e)
                        $display("FAIL pixel_order: px_addr %0d, required %0d", px_addr, e);
                    else npass++;
                end
            end
            hold_q    = px_valid && !px_ready;
            hold_addr = px_addr;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        wr_pulse = 1'b0;
        clear    = 1'b0;
        vblank   = 1'b0;
        px_ready = 1'b0;
        bwp      = 0;
        bfill    = 0;
        exp_q.delete();
        repeat (2) tick();
        resetn = 1'b1;
        tick();
    endtask

    task automatic write_px(input logic [DATA_W-1:0] d);
        wr_pulse = 1'b1;
        mem[bwp] = d;
        bwp      = (bwp + 1) % int'(DEPTH);
        if (bfill < int'(DEPTH)) bfill++;
        tick();
        wr_pulse = 1'b0;
    endtask

    // Queue the pixels a full pass must deliver, then open blanking.
    task automatic start_pass();
        int start;
        start = (bfill < int'(DEPTH)) ? 0 : bwp;
        for (int i = 0; i < bfill; i++) begin
            if (mem[(start + i) % int'(DEPTH)] < PIXLIM)
                exp_q.push_back(mem[(start + i) % int'(DEPTH)]);
        end
        vblank = 1'b1;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (px_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        ntotal++;
        if ({rd_draw_add, px_valid, px_addr, busy, frame_done, aborted} !== '0)
            $display("FAIL reset_outputs: add=%0d v=%0b addr=%0d busy=%0b fd=%0b ab=%0b, required all 0",
                     rd_draw_add, px_valid, px_addr, busy, frame_done, aborted);
        else npass++;
        ntotal++;
        if (px_color !== 8'hE0) $display("FAIL reset_color: px_color %0h, required e0", px_color);
        else npass++;
        ntotal++;
        if (dut.u_fill.fill_o !== '0) $display("FAIL reset_fill: fill %0d, required 0", dut.u_fill.fill_o);
        else npass++;
        do_reset();
    endtask

    task automatic test_basic();
        int n, xb, fb, ab;
        bit found;
        do_reset();
        write_px(19'd10);
        write_px(19'd20);
        write_px(19'd30);
        px_ready = 1'b1;
        xb = xfer_cnt; fb = fd_cnt; ab = ab_cnt;
        start_pass();
        tick();
        found = 1'b0;
        for (n = 1; n <= 100; n++) begin
            tick();
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        ntotal++;
        if (!found || n != 3 * (RD_LAT + 3) + 1)
            $display("FAIL basic_latency: frame_done after %0d cycles (seen=%0b), required %0d",
                     n, found, 3 * (RD_LAT + 3) + 1);
        else npass++;
        repeat (2) tick();
        ntotal++;
        if (xfer_cnt - xb != 3 || exp_q.size() != 0)
            $display("FAIL basic_count: transfers %0d left %0d, required 3 and 0", xfer_cnt - xb, exp_q.size());
        else npass++;
        ntotal++;
        if (fd_cnt - fb != 1 || ab_cnt != ab)
            $display("FAIL basic_pulses: frame_done %0d aborted %0d, required 1 and 0", fd_cnt - fb, ab_cnt - ab);
        else npass++;
        vblank = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int xb, k;
        bit found;
        do_reset();
        write_px(19'd100);
        px_ready = 1'b0;
        xb = xfer_cnt;
        start_pass();
        wait_valid(ok);
        ntotal++;
        if (!ok) $display("FAIL bp_valid_timeout: px_valid %0b, required 1", px_valid);
        else npass++;
        for (k = 0; k < 7; k++) begin
            ntotal++;
            if (px_valid !== 1'b1 || px_addr !== 19'd100)
                $display("FAIL bp_hold: valid %0b addr %0d, required 1 and 100", px_valid, px_addr);
            else npass++;
            tick();
        end
        px_ready = 1'b1;
        found = 1'b0;
        for (k = 0; k < 20; k++) begin
            tick();
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        ntotal++;
        if (!found || xfer_cnt - xb != 1)
            $display("FAIL bp_single_xfer: transfers %0d (done=%0b), required 1", xfer_cnt - xb, found);
        else npass++;
        vblank = 1'b0;
    endtask

    task automatic test_abort();
        bit ok, found;
        int xb, fb, ab;
        do_reset();
        write_px(19'd5);
        write_px(19'd6);
        write_px(19'd7);
        px_ready = 1'b0;
        xb = xfer_cnt; fb = fd_cnt; ab = ab_cnt;
        start_pass();
        wait_valid(ok);
        ntotal++;
        if (!ok) $display("FAIL abort_valid_timeout: px_valid %0b, required 1", px_valid);
        else npass++;
        vblank = 1'b0;
        repeat (2) begin
            tick();
            ntotal++;
            if (px_valid !== 1'b1 || aborted !== 1'b0)
                $display("FAIL abort_hold: valid %0b aborted %0b, required 1 and 0", px_valid, aborted);
            else npass++;
        end
        px_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (aborted) begin
                found = 1'b1;
                break;
            end
        end
        repeat (3) tick();
        ntotal++;
        if (!found || ab_cnt - ab != 1 || fd_cnt != fb)
            $display("FAIL abort_pulse: aborted %0d frame_done %0d, required 1 and 0", ab_cnt - ab, fd_cnt - fb);
        else npass++;
        ntotal++;
        if (xfer_cnt - xb != 1 || exp_q.size() != 2 || busy !== 1'b0)
            $display("FAIL abort_drain: transfers %0d left %0d busy %0b, required 1, 2, 0",
                     xfer_cnt - xb, exp_q.size(), busy);
        else npass++;
        exp_q.delete();
    endtask

    task automatic test_clear_collision();
        int vb, fb;
        do_reset();
        write_px(19'd1);
        write_px(19'd2);
        clear    = 1'b1;
        wr_pulse = 1'b1;
        tick();
        clear    = 1'b0;
        wr_pulse = 1'b0;
        bwp   = 0;
        bfill = 0;
        ntotal++;
        if (dut.u_fill.fill_o !== '0) $display("FAIL clear_fill: fill %0d, required 0", dut.u_fill.fill_o);
        else npass++;
        vb = valid_cnt; fb = fd_cnt;
        start_pass();
        tick();
        ntotal++;
        if (frame_done !== 1'b1 || busy !== 1'b0)
            $display("FAIL clear_frame_done: frame_done %0b busy %0b, required 1 and 0", frame_done, busy);
        else npass++;
        repeat (4) tick();
        ntotal++;
        if (valid_cnt != vb || fd_cnt - fb != 1)
            $display("FAIL clear_no_pixels: valid cycles %0d frame_done %0d, required 0 and 1", valid_cnt - vb, fd_cnt - fb);
        else npass++;
        vblank = 1'b0;
    endtask

    task automatic test_wrap_skip();
        int xb, ab;
        bit found;
        do_reset();
        for (int k = 0; k < 405; k++)
            write_px((k == 404) ? pix_loc(0, 480) : 19'(k * 7 + 3));
        px_ready = 1'b1;
        xb = xfer_cnt; ab = ab_cnt;
        start_pass();
        tick();
        ntotal++;
        if (rd_draw_add !== 9'd5 || busy !== 1'b1)
            $display("FAIL wrap_start: rd_draw_add %0d busy %0b, required 5 and 1", rd_draw_add, busy);
        else npass++;
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            px_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (frame_done) begin
                found = 1'b1;
                break;
            end
        end
        px_ready = 1'b1;
        ntotal++;
        if (!found || xfer_cnt - xb != 399 || exp_q.size() != 0 || ab_cnt != ab)
            $display("FAIL wrap_pass: done %0b transfers %0d left %0d, required 1, 399, 0",
                     found, xfer_cnt - xb, exp_q.size());
        else npass++;
        vblank = 1'b0;
    endtask

    task automatic test_reset_mid_pass();
        bit ok;
        int xb;
        do_reset();
        write_px(19'd42);
        write_px(19'd43);
        px_ready = 1'b1;
        xb = xfer_cnt;
        start_pass();
        for (int i = 0; i < 50; i++) begin
            tick();
            if (xfer_cnt > xb) break;
        end
        px_ready = 1'b0;
        wait_valid(ok);
        ntotal++;
        if (!ok || px_addr !== 19'd43 || rd_draw_add !== 9'd1)
            $display("FAIL midpass_setup: valid %0b addr %0d add %0d, required 1, 43, 1", ok, px_addr, rd_draw_add);
        else npass++;
        #2;
        resetn = 1'b0;
        #1;
        ntotal++;
        if ({rd_draw_add, px_valid, px_addr, busy, frame_done, aborted} !== '0 || dut.state_q !== ST_IDLE)
            $display("FAIL midpass_reset: add=%0d v=%0b addr=%0d busy=%0b state=%0d, required all 0",
                     rd_draw_add, px_valid, px_addr, busy, dut.state_q);
        else npass++;
        exp_q.delete();
        tick();
        resetn = 1'b1;
        vblank = 1'b0;
        tick();
    endtask

    initial begin
        #1;
        test_reset();
        test_basic();
        test_backpressure();
        test_abort();
        test_clear_collision();
        test_wrap_skip();
        test_reset_mid_pass();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
